uart_bus_bridge: RTL and testbench
==================================

# uart_bus_bridge

Serial debug/loader initiator for the SoC memory-mapped bus. It receives 8N1 command frames on a UART RX pin and performs 32-bit bus reads and writes with the same addr/we/data semantics the CPU uses. Results go back on a UART TX pin. It sits beside the CPU, in front of the bus address decoder, and gains bus ownership through a request/grant handshake (the CPU is stalled or held in reset while granted), so a host PC can load RAM and poke peripherals.

## Interface
- CLKS_PER_BIT, default 87: clock cycles per serial bit (baud = f_clk / CLKS_PER_BIT); must be ≥ 8.
- TIMEOUT_CYCLES, default 1_000_000: maximum idle gap between bytes of one frame before the frame is aborted.
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rx_i  in  1  serial input, idle high, asynchronous to clk_i.
- tx_o  out  1  serial output, idle high.
- busreq_o  out  1  bus ownership request.
- gnt_i  in  1  bus grant; bridge drives the bus only while gnt_i=1.
- addr_o  out  32  bus address.
- data_o  out  32  bus write data.
- we_o  out  1  bus write enable, one-cycle pulse.
- data_i  in  32  bus read data (combinational path from decoder, valid same cycle as addr_o).
- busy_o  out  1  high from first opcode byte until last response bit is sent.
- frame_err_o  out  1  one-cycle pulse per RX byte with stop bit = 0.

## Operation
- RX: 2-flop synchronizer on rx_i. A falling edge in idle starts a counter. The start bit is re-checked at CLKS_PER_BIT/2; if it reads high, the edge was a glitch and RX returns to idle. Data bits are sampled LSB first at mid-bit. The stop bit is sampled at mid-bit: 1 → byte valid (1-cycle strobe), 0 → frame_err_o pulse and the byte is discarded.
- TX: 8N1, LSB first. Loaded only when idle. Sends start(0), 8 data, stop(1).
- Frame format, multi-byte fields MSB first:
  - Write: 0x57, A3..A0, D3..D0. Response 0x4B.
  - Read: 0x52, A3..A0. Response D3..D0.
  - Any other opcode: response 0x3F, return to IDLE.
- FSM states: IDLE → OPC → ADDR (4 bytes) → DATA (4 bytes, write only) → REQ → ACCESS → RESP → IDLE.
- REQ: busreq_o=1, waits indefinitely for gnt_i.
- ACCESS: exactly one cycle with gnt_i=1.
  - Write: we_o=1, addr_o/data_o stable.
  - Read: data_i captured into the response shift register at the clock edge ending ACCESS.
  - busreq_o drops the cycle after ACCESS.
- RESP: bytes queued back-to-back; the next byte loads the cycle TX returns to idle.
- Timeout: an inter-byte counter in ADDR/DATA reloads on each RX byte. On expiry → IDLE, no bus access, no response, partial address/data discarded.
- RX bytes arriving during REQ/ACCESS/RESP are dropped.
- A framing error inside a frame aborts the frame (→ IDLE).
- Reset mid-operation (any state, including mid-TX bit or REQ) returns everything to reset values on the next edge. No we_o may be emitted after reset assertion.

## Timing
- Reset values: tx_o=1, busreq_o=0, addr_o=0, data_o=0, we_o=0, busy_o=0, frame_err_o=0, FSM=IDLE.
- RX byte strobe occurs 2 (synchronizer) + ~9.5·CLKS_PER_BIT cycles after the start-bit falling edge on rx_i.
- Last-byte strobe → busreq_o: 1 cycle. gnt_i high → ACCESS: next cycle. ACCESS → first TX start bit: 2 cycles.
- Each TX bit lasts exactly CLKS_PER_BIT cycles. A frame is 10·CLKS_PER_BIT cycles, with no idle gap between response bytes.
- addr_o/data_o are held from REQ entry until returning to IDLE; we_o is high only in ACCESS.
- gnt_i dropping while in REQ has no effect until it rises again. gnt_i is ignored outside REQ/ACCESS.

## Test plan
- Write: send 57 00 00 00 10 DE AD BE EF → after gnt_i, one we_o pulse with addr_o=0x00000010, data_o=0xDEADBEEF; TX returns 0x4B.
- Read: data_i=0x12345678 at addr 0x00000020, send 52 00 00 00 20 → TX bytes 12 34 56 78, no we_o.
- Delayed grant: hold gnt_i=0 for 500 cycles after the last byte → busreq_o stays 1, no we_o; access occurs the cycle after gnt_i rises.
- Bad opcode 0xAA → TX 0x3F, busreq_o never asserts; a following valid write then completes normally.
- Timeout/framing error: stop sending after 57 00 00 past TIMEOUT_CYCLES, or send a byte with stop=0 mid-frame → no bus access; frame_err_o pulses once for the bad stop bit; the next full frame succeeds.
- Reset mid-RESP and mid-REQ → tx_o=1, busreq_o=0, busy_o=0 the next cycle; no spurious we_o.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// UART (8N1) command bridge that issues single 32-bit bus reads/writes for a host debugger.
// Latency: last RX byte -> busreq_o 1 cycle; grant -> access next cycle; access -> TX start 2 cycles.
// Backpressure: waits indefinitely for gnt_i; RX bytes arriving during REQ/ACCESS/RESP are dropped.
module uart_bus_bridge #(
    parameter int CLKS_PER_BIT   = 87,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        busreq_o,
    input  logic        gnt_i,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic        we_o,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic        frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OPC_WR   = 8'h57;
    localparam logic [7:0] OPC_RD   = 8'h52;
    localparam logic [7:0] RESP_ACK = 8'h4B;
    localparam logic [7:0] RESP_BAD = 8'h3F;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sr;
    logic          rx_vld;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_sr       <= '0;
            rx_vld      <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_s1       <= rx_i;
            rx_s2       <= rx_s1;
            rx_prev     <= rx_s2;
            rx_vld      <= 1'b0;
            frame_err_o <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at half-bit was a glitch.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_sr  <= {rx_s2, rx_sr[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) rx_vld      <= 1'b1;
                        else       frame_err_o <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic          tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sr;
    logic          tx_rdy;
    logic          tx_vld;
    logic [7:0]    tx_dat;

    // Ready during the last stop-bit cycle too, so queued bytes go out with no idle gap.
    assign tx_rdy = !tx_busy || (tx_bit == 4'd9 && tx_cnt == BIT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_o    <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sr   <= '1;
        end else if (tx_vld && tx_rdy) begin
            tx_o    <= 1'b0;
            tx_sr   <= {1'b1, tx_dat};
            tx_busy <= 1'b1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
        end else if (tx_busy) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_o    <= 1'b1;
                end else begin
                    tx_o   <= tx_sr[0];
                    tx_sr  <= {1'b1, tx_sr[8:1]};
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE, S_OPC, S_ADDR, S_DATA, S_REQ, S_ACCESS, S_RESP
    } state_t;

    state_t        state;
    logic [7:0]    opc;
    logic          is_wr;
    logic [1:0]    byte_cnt;
    logic [31:0]   addr_sr;
    logic [31:0]   data_sr;
    logic [TW-1:0] to_cnt;
    logic [31:0]   resp_sr;
    logic [2:0]    resp_left;

    assign tx_vld = (state == S_RESP) && (resp_left != 3'd0);
    assign tx_dat = resp_sr[31:24];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            opc       <= '0;
            is_wr     <= 1'b0;
            byte_cnt  <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            to_cnt    <= '0;
            resp_sr   <= '0;
            resp_left <= '0;
            busreq_o  <= 1'b0;
            addr_o    <= '0;
            data_o    <= '0;
            we_o      <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            we_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_vld) begin
                        opc    <= rx_sr;
                        busy_o <= 1'b1;
                        state  <= S_OPC;
                    end
                end
                S_OPC: begin
                    byte_cnt <= '0;
                    to_cnt   <= '0;
                    if (opc == OPC_WR || opc == OPC_RD) begin
                        is_wr <= (opc == OPC_WR);
                        state <= S_ADDR;
                    end else begin
                        resp_sr   <= {RESP_BAD, 24'h0};
                        resp_left <= 3'd1;
                        state     <= S_RESP;
                    end
                end
                S_ADDR: begin
                    if (frame_err_o) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else if (rx_vld) begin
                        addr_sr  <= {addr_sr[23:0], rx_sr};
                        to_cnt   <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (is_wr) begin
                                state <= S_DATA;
                            end else begin
                                state    <= S_REQ;
                                busreq_o <= 1'b1;
                                addr_o   <= {addr_sr[23:0], rx_sr};
                            end
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (frame_err_o) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else if (rx_vld) begin
                        data_sr  <= {data_sr[23:0], rx_sr};
                        to_cnt   <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= S_REQ;
                            busreq_o <= 1'b1;
                            addr_o   <= addr_sr;
                            data_o   <= {data_sr[23:0], rx_sr};
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    if (gnt_i) begin
                        state <= S_ACCESS;
                        we_o  <= is_wr;
                    end
                end
                S_ACCESS: begin
                    busreq_o <= 1'b0;
                    state    <= S_RESP;
                    if (is_wr) begin
                        resp_sr   <= {RESP_ACK, 24'h0};
                        resp_left <= 3'd1;
                    end else begin
                        resp_sr   <= data_i;
                        resp_left <= 3'd4;
                    end
                end
                S_RESP: begin
                    if (tx_vld && tx_rdy) begin
                        resp_sr   <= {resp_sr[23:0], 8'h0};
                        resp_left <= resp_left - 3'd1;
                    end else if (resp_left == 3'd0 && !tx_busy) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: serial host driver, bus slave, TX decoder and frame-level reference model.
module tb_uart_bus_bridge;

    localparam int CPB = 8;
    localparam int TO  = 2000;

    logic        clk = 1'b0;
    logic        rst, rx, tx, busreq, gnt, we, busy, ferr;
    logic [31:0] addr, wdata, rdata;

    always #5 clk = ~clk;

    uart_bus_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx), .tx_o(tx),
        .busreq_o(busreq), .gnt_i(gnt), .addr_o(addr), .data_o(wdata),
        .we_o(we), .data_i(rdata), .busy_o(busy), .frame_err_o(ferr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bus slave: 16 words aliased on addr[5:2]; unwritten words return a fixed hash.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h1234_5678;
    endfunction

    logic [31:0] slave_mem [16];
    logic [15:0] slave_valid = '0;
    assign rdata = slave_valid[addr[5:2]] ? slave_mem[addr[5:2]] : dflt(addr);
    always @(posedge clk) begin
        if (we) begin
            slave_mem[addr[5:2]]   <= wdata;
            slave_valid[addr[5:2]] <= 1'b1;
        end
    end

    // Reference model of the same memory, updated from the frames the bench sends.
    logic [31:0] model_mem [16];
    logic [15:0] model_valid = '0;
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_valid[a[5:2]] ? model_mem[a[5:2]] : dflt(a);
    endfunction

    // Monitors sampled on the falling edge.
    int          cyc = 0;
    logic [63:0] we_q[$];
    int          we_cyc = 0, tx_fall_cyc = 0, ferr_cnt = 0;
    bit          fall_pending = 0, busreq_seen = 0;
    logic        tx_prev = 1'b1;
    logic [8:0]  rxq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            we_q.push_back({addr, wdata});
            we_cyc       = cyc;
            fall_pending = 1;
        end
        if (tx_prev && !tx && fall_pending) begin
            tx_fall_cyc  = cyc;
            fall_pending = 0;
        end
        tx_prev = tx;
        if (ferr) ferr_cnt++;
        if (busreq) busreq_seen = 1;
    end

    initial begin : tx_decoder
        logic [7:0] b;
        logic       sb;
        b = '0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                sb = tx;
                rxq.push_back({sb, b});
            end
        end
    end

    // Automatic grant after a programmable delay.
    bit gnt_auto  = 1;
    int gnt_delay = 0;
    initial begin : granter
        gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt_auto && busreq && !gnt) begin
                repeat (gnt_delay) @(negedge clk);
                gnt = 1'b1;
            end else if (gnt_auto && !busreq) begin
                gnt = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] d);
        send_byte(opc, 1'b1);
        if (opc == 8'h57 || opc == 8'h52)
            for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
        if (opc == 8'h57)
            for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_drop_in_time", 64'(n < limit), 64'd1);
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic clear_mon();
        rxq.delete();
        we_q.delete();
        busreq_seen  = 0;
        fall_pending = 0;
        ferr_cnt     = 0;
    endtask

    // One complete transaction with expected response bytes and bus writes.
    task automatic run_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] d,
                             input int gd, input int n, input logic [31:0] resp, input int nwe);
        logic [31:0] r;
        clear_mon();
        gnt_delay = gd;
        send_frame(opc, a, d);
        wait_idle(2000 + gd);
        check("tx_byte_count", 64'(rxq.size()), 64'(n));
        r = resp;
        for (int i = 0; i < n && i < rxq.size(); i++) begin
            check("tx_byte", 64'(rxq[i]), 64'({1'b1, r[31:24]}));
            r = r << 8;
        end
        check("we_count", 64'(we_q.size()), 64'(nwe));
        if (nwe == 1 && we_q.size() > 0) begin
            check("we_addr_data", we_q[0], {a, d});
            check("access_to_tx_start", 64'(tx_fall_cyc - we_cyc), 64'd2);
        end
        check("busreq_seen", 64'(busreq_seen), 64'(opc == 8'h57 || opc == 8'h52));
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        model_mem[a[5:2]]   = d;
        model_valid[a[5:2]] = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  opc;
        logic [31:0] a;
        logic [31:0] d;
        int          gd;
        int          n;
        logic [31:0] resp;
        int          nwe;
    } vec_t;

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : main
        vec_t tbl[5];
        int   bad, n, gcyc;
        logic [31:0] a, d, exp;
        logic [7:0]  opc;

        tbl[0] = '{8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 3, 1, 32'h4B00_0000, 1};
        tbl[1] = '{8'h57, 32'h0000_0020, 32'h1234_5678, 0, 1, 32'h4B00_0000, 1};
        tbl[2] = '{8'h52, 32'h0000_0020, 32'h0,         5, 4, 32'h1234_5678, 0};
        tbl[3] = '{8'hAA, 32'h0,         32'h0,         0, 1, 32'h3F00_0000, 0};
        tbl[4] = '{8'h52, 32'h0000_0010, 32'h0,         1, 4, 32'hDEAD_BEEF, 0};

        rx  = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_tx",       64'(tx),     64'd1);
        check("rst_busreq",   64'(busreq), 64'd0);
        check("rst_addr",     64'(addr),   64'd0);
        check("rst_data",     64'(wdata),  64'd0);
        check("rst_we",       64'(we),     64'd0);
        check("rst_busy",     64'(busy),   64'd0);
        check("rst_frame_err", 64'(ferr),  64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        foreach (tbl[i]) begin
            run_frame(tbl[i].opc, tbl[i].a, tbl[i].d, tbl[i].gd, tbl[i].n, tbl[i].resp, tbl[i].nwe);
            if (tbl[i].opc == 8'h57) model_write(tbl[i].a, tbl[i].d);
        end

        // Delayed grant: request must hold for 500 cycles with no access.
        gnt_auto = 0;
        gnt = 1'b0;
        clear_mon();
        send_frame(8'h57, 32'h0000_0040, 32'hCAFE_F00D);
        n = 0;
        while (!busreq && n < 200) begin @(negedge clk); n++; end
        check("dly_busreq_up", 64'(busreq), 64'd1);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (!busreq || we) bad++;
        end
        check("dly_hold_no_access", 64'(bad), 64'd0);
        gnt = 1'b1;
        gcyc = cyc;
        @(negedge clk);
        check("dly_we_next_cycle", 64'(we), 64'd1);
        check("dly_access_cycle", 64'(cyc - gcyc), 64'd1);
        check("dly_addr", 64'(addr), 64'h40);
        @(negedge clk);
        check("dly_we_one_pulse", 64'(we), 64'd0);
        check("dly_busreq_drop", 64'(busreq), 64'd0);
        gnt = 1'b0;
        gnt_auto = 1;
        wait_idle(2000);
        check("dly_resp", 64'(rxq.size() > 0 ? rxq[0] : 9'h0), 64'h14B);
        model_write(32'h40, 32'hCAFE_F00D);

        // Abandoned frame: timeout, then a full frame still works.
        clear_mon();
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (TO + 200) @(negedge clk);
        check("to_no_busreq", 64'(busreq_seen), 64'd0);
        check("to_busy_low", 64'(busy), 64'd0);
        check("to_no_tx", 64'(rxq.size()), 64'd0);
        run_frame(8'h57, 32'h0000_0004, 32'h0BAD_CAFE, 2, 1, 32'h4B00_0000, 1);
        model_write(32'h4, 32'h0BAD_CAFE);

        // Bad stop bit mid-frame aborts the frame.
        clear_mon();
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        check("ferr_pulses", 64'(ferr_cnt), 64'd1);
        check("ferr_busy_low", 64'(busy), 64'd0);
        check("ferr_no_busreq", 64'(busreq_seen), 64'd0);
        run_frame(8'h52, 32'h0000_0004, 32'h0, 0, 4, 32'h0BAD_CAFE, 0);

        // Randomized frames against the model.
        for (int i = 0; i < 10; i++) begin
            a = $urandom();
            a[5:2] = 4'($urandom_range(0, 8));
            d = $urandom();
            case ($urandom_range(0, 4))
                0, 1:    opc = 8'h57;
                2, 3:    opc = 8'h52;
                default: opc = 8'($urandom_range(0, 255)) | 8'h80;
            endcase
            if (opc == 8'h57) begin
                run_frame(opc, a, d, $urandom_range(0, 15), 1, 32'h4B00_0000, 1);
                model_write(a, d);
            end else if (opc == 8'h52) begin
                exp = model_rd(a);
                run_frame(opc, a, d, $urandom_range(0, 15), 4, exp, 0);
            end else begin
                run_frame(opc, a, d, 0, 1, 32'h3F00_0000, 0);
            end
        end

        // Reset in the middle of the response.
        clear_mon();
        send_frame(8'h52, 32'h0000_0010, 32'h0);
        n = 0;
        while (rxq.size() < 1 && n < 3000) begin @(negedge clk); n++; end
        check("rresp_first_byte", 64'(rxq.size() >= 1), 64'd1);
        repeat (CPB * 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rresp_tx", 64'(tx), 64'd1);
        check("rresp_busreq", 64'(busreq), 64'd0);
        check("rresp_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (20 * CPB) @(negedge clk);

        // Reset while waiting for grant: the pending write must never happen.
        gnt_auto = 0;
        gnt = 1'b0;
        clear_mon();
        send_frame(8'h57, 32'h0000_0008, 32'h5555_AAAA);
        n = 0;
        while (!busreq && n < 200) begin @(negedge clk); n++; end
        check("rreq_busreq_up", 64'(busreq), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rreq_tx", 64'(tx), 64'd1);
        check("rreq_busreq", 64'(busreq), 64'd0);
        check("rreq_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        gnt = 1'b1;
        repeat (10) @(negedge clk);
        gnt = 1'b0;
        gnt_auto = 1;
        check("rreq_no_we", 64'(we_q.size()), 64'd0);
        repeat (20 * CPB) @(negedge clk);

        run_frame(8'h52, 32'h0000_0040, 32'h0, 4, 4, model_rd(32'h40), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
